// File: rtl/lsu_pkg.sv
// Shared types for the load/store Wishbone initiator.
// Enumerates access sizes and the bus FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_BUS  = 2'd1,
    STATE_RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/wb_bus.sv
// Classic Wishbone bus bundle between one initiator and one target.
// The master modport is the initiator view used by wb_lsu_master.
interface wb_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;

  modport master (
    output addr, wdata, sel, we, stb, cyc,
    input  rdata, ack, err
  );

  modport slave (
    input  addr, wdata, sel, we, stb, cyc,
    output rdata, ack, err
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: sel/wdata generation, load extraction and
// extension, and the misalignment check. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  size_t       size_in,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  input  logic        uns_in,
  output logic [3:0]  sel_out,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        misalign_out
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_in[{addr_lo, 3'b000} +: 8];
  assign half_v = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];

  always_comb begin
    sel_out      = 4'b0000;
    wdata_out    = wdata_in;
    rdata_out    = 32'h0;
    misalign_out = 1'b0;
    unique case (size_in)
      SIZE_BYTE: begin
        sel_out   = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{~uns_in & byte_v[7]}}, byte_v};
      end
      SIZE_HALF: begin
        misalign_out = addr_lo[0];
        sel_out      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out    = {2{wdata_in[15:0]}};
        rdata_out    = {{16{~uns_in & half_v[15]}}, half_v};
      end
      SIZE_WORD: begin
        misalign_out = |addr_lo;
        sel_out      = 4'b1111;
        rdata_out    = rdata_in;
      end
      default: begin
        misalign_out = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone initiator for the load/store stage: one classic cycle per
// request. Optional bus timeout abort: define WB_LSU_TIMEOUT_EN.
module wb_lsu_master
  import lsu_pkg::*;
`ifdef WB_LSU_TIMEOUT_EN
#(
  parameter int unsigned TimeoutCycles = 255
)
`endif
(
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  wb_bus.master       bus_master
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  size_t       size_q, size_d;
  logic        uns_q, uns_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        idle;
  size_t       al_size;
  logic [1:0]  al_addr;
  logic        al_uns;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;
  logic        tmo;

  assign idle = (state_q == STATE_IDLE);

  // In IDLE the lane logic looks at the new request, otherwise at the
  // captured one so the ack-edge load extraction uses the right lane.
  assign al_size = idle ? size_t'(req_size) : size_q;
  assign al_addr = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_uns  = idle ? req_unsigned : uns_q;

  lsu_align u_align (
    .size_in      (al_size),
    .addr_lo      (al_addr),
    .wdata_in     (req_wdata),
    .rdata_in     (bus_master.rdata),
    .uns_in       (al_uns),
    .sel_out      (al_sel),
    .wdata_out    (al_wdata),
    .rdata_out    (al_rdata),
    .misalign_out (al_mis)
  );

`ifdef WB_LSU_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  assign tmo = (state_q == STATE_BUS) &&
               (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == STATE_BUS)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= STATE_IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STATE_IDLE: begin
        if (req_valid)
          state_d = al_mis ? STATE_RESP : STATE_BUS;
      end
      STATE_BUS: begin
        if (bus_master.ack || bus_master.err || tmo)
          state_d = STATE_RESP;
      end
      STATE_RESP: state_d = STATE_IDLE;
      default:    state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      STATE_IDLE: begin
        if (req_valid) begin
          rsp_rdata_d = 32'h0;
          rsp_err_d   = al_mis;
          if (!al_mis) begin
            addr_d  = req_addr;
            wdata_d = al_wdata;
            sel_d   = al_sel;
            we_d    = req_we;
            size_d  = size_t'(req_size);
            uns_d   = req_unsigned;
            cyc_d   = 1'b1;
          end
        end
      end
      STATE_BUS: begin
        if (bus_master.err || tmo) begin
          cyc_d       = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else if (bus_master.ack) begin
          cyc_d       = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : al_rdata;
        end
      end
      STATE_RESP: begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
      default: begin
        cyc_d = 1'b0;
      end
    endcase
  end

  assign req_ready = idle && !reset_in;
  assign rsp_valid = (state_q == STATE_RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign bus_master.addr  = addr_q;
  assign bus_master.wdata = wdata_q;
  assign bus_master.sel   = sel_q;
  assign bus_master.we    = we_q;
  assign bus_master.cyc   = cyc_q;
  assign bus_master.stb   = cyc_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master against a small data memory model
// with selectable ack, err and silent slave behaviour.
module tb_wb_lsu_master;
  import lsu_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  wb_bus bus ();

  always #5 clk_in = ~clk_in;

`ifdef WB_LSU_TIMEOUT_EN
  wb_lsu_master #(.TimeoutCycles(4)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bus_master   (bus)
  );
`else
  wb_lsu_master dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bus_master   (bus)
  );
`endif

  logic [1:0]  mode = 2'd0;
  logic        ack_q = 1'b0;
  logic [31:0] mem [16];

  always @(posedge clk_in) begin
    ack_q <= (mode == 2'd0) && bus.cyc && bus.stb && !ack_q;
    if (mode == 2'd0 && bus.ack && bus.stb && bus.we) begin
      for (int l = 0; l < 4; l++)
        if (bus.sel[l])
          mem[bus.addr[5:2]][8*l +: 8] <= bus.wdata[8*l +: 8];
    end
  end

  assign bus.ack   = (mode == 2'd0) ? ack_q :
                     (mode == 2'd1) ? (bus.cyc && bus.stb) : 1'b0;
  assign bus.err   = (mode == 2'd1) && bus.cyc && bus.stb;
  assign bus.rdata = mem[bus.addr[5:2]];

  int          stb_cnt = 0;
  int          ack_cnt = 0;
  logic [3:0]  mon_sel = 4'h0;
  logic [31:0] mon_addr = 32'h0;
  logic [31:0] mon_wdata = 32'h0;

  always @(posedge clk_in) begin
    if (bus.cyc || bus.stb) begin
      stb_cnt++;
      mon_sel   = bus.sel;
      mon_addr  = bus.addr;
      mon_wdata = bus.wdata;
      if (bus.ack) ack_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nstb,
                        output int nack);
    int s0;
    int a0;
    s0 = stb_cnt;
    a0 = ack_cnt;
    @(negedge clk_in);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk_in);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk_in);
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    @(negedge clk_in);
    check("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    nstb = stb_cnt - s0;
    nack = ack_cnt - a0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nstb, nack;
  logic        seen;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #1 reset_in = 1'b1;
    #10;
    check("rst_cyc", {31'h0, bus.cyc}, 32'h0);
    check("rst_stb", {31'h0, bus.stb}, 32'h0);
    check("rst_we", {31'h0, bus.we}, 32'h0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_sel", {28'h0, bus.sel}, 32'h0);
    check("rst_wdata", bus.wdata, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk_in) reset_in = 1'b0;
    #1 check("idle_ready", {31'h0, req_ready}, 32'h1);

    do_req(1'b1, 2'd2, 1'b0, 32'h3004, 32'hDEADBEEF,
           rd, er, lat, nstb, nack);
    check("sw_lat", lat, 3);
    check("sw_err", {31'h0, er}, 32'h0);
    check("sw_rdata", rd, 32'h0);
    check("sw_sel", {28'h0, mon_sel}, 32'hF);
    check("sw_addr", mon_addr, 32'h3004);
    check("sw_acks", nack, 1);

    do_req(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0,
           rd, er, lat, nstb, nack);
    check("lw_lat", lat, 3);
    check("lw_data", rd, 32'hDEADBEEF);

    do_req(1'b1, 2'd0, 1'b0, 32'h3001, 32'hFFFF1280,
           rd, er, lat, nstb, nack);
    check("sb_sel", {28'h0, mon_sel}, 32'h2);
    check("sb_wdata", mon_wdata, 32'h80808080);
    check("sb_err", {31'h0, er}, 32'h0);

    do_req(1'b0, 2'd0, 1'b0, 32'h3001, 32'h0,
           rd, er, lat, nstb, nack);
    check("lb_data", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h3001, 32'h0,
           rd, er, lat, nstb, nack);
    check("lbu_data", rd, 32'h00000080);

    do_req(1'b1, 2'd2, 1'b0, 32'h3000, 32'h80011234,
           rd, er, lat, nstb, nack);
    do_req(1'b0, 2'd1, 1'b0, 32'h3002, 32'h0,
           rd, er, lat, nstb, nack);
    check("lh_sel", {28'h0, mon_sel}, 32'hC);
    check("lh_data", rd, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h3002, 32'h0,
           rd, er, lat, nstb, nack);
    check("lhu_data", rd, 32'h00008001);
    do_req(1'b0, 2'd0, 1'b0, 32'h3000, 32'h0,
           rd, er, lat, nstb, nack);
    check("lb0_data", rd, 32'h00000034);

    do_req(1'b0, 2'd1, 1'b0, 32'h3003, 32'h0,
           rd, er, lat, nstb, nack);
    check("mis_h_err", {31'h0, er}, 32'h1);
    check("mis_h_lat", lat, 1);
    check("mis_h_bus", nstb, 0);
    check("mis_h_rdata", rd, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h3002, 32'h0,
           rd, er, lat, nstb, nack);
    check("mis_w_err", {31'h0, er}, 32'h1);
    check("mis_w_lat", lat, 1);
    check("mis_w_bus", nstb, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h3000, 32'h0,
           rd, er, lat, nstb, nack);
    check("rsvd_err", {31'h0, er}, 32'h1);
    check("rsvd_lat", lat, 1);
    check("rsvd_bus", nstb, 0);

    mode = 2'd1;
    do_req(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0,
           rd, er, lat, nstb, nack);
    check("berr_err", {31'h0, er}, 32'h1);
    check("berr_rdata", rd, 32'h0);
    check("berr_lat", lat, 2);
    check("berr_stb", nstb, 1);

    mode = 2'd2;
    @(negedge clk_in);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h3000; req_valid = 1'b1;
    @(posedge clk_in);
    #1 req_valid = 1'b0;
    @(negedge clk_in);
    check("mid_stb_up", {31'h0, bus.stb}, 32'h1);
    #2 reset_in = 1'b1;
    #1;
    check("mid_rst_cyc", {31'h0, bus.cyc}, 32'h0);
    check("mid_rst_stb", {31'h0, bus.stb}, 32'h0);
    check("mid_rst_ready", {31'h0, req_ready}, 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_in);
      seen |= rsp_valid;
    end
    reset_in = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_in);
      seen |= rsp_valid;
    end
    check("mid_rst_no_rsp", {31'h0, seen}, 32'h0);

`ifdef WB_LSU_TIMEOUT_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0,
           rd, er, lat, nstb, nack);
    check("tmo_stb", nstb, 4);
    check("tmo_err", {31'h0, er}, 32'h1);
    check("tmo_lat", lat, 5);
`endif

    mode = 2'd0;
    do_req(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0,
           rd, er, lat, nstb, nack);
    check("recover_data", rd, 32'h80011234);
    check("recover_err", {31'h0, er}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone initiator between the CPU load/store stage and the SoC bus. It drives transactions toward peripherals such as data memory.
- Accepts one byte, half or word load/store request at a time and generates the lane-aligned sel and wdata.
- Runs a single classic Wishbone cycle, then returns a sign- or zero-extended read result or an error in a one-cycle response.
- Checks alignment locally, so misaligned accesses never reach the bus.

Parameters:
- TimeoutCycles, 255, maximum cycles stb may wait for ack/err before abort. Used only when the timeout feature is compiled in. Must be at least 1.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  input  1  zero-extend load result (LBU/LHU)
- req_addr  input  32  absolute byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned, reserved size, bus err or timeout; qualified by rsp_valid
- bus_master  wb_bus.master  -  addr, wdata, sel, we, stb, cyc out; rdata, ack, err in

Behaviour:
- Reset (asynchronous, active-high): state IDLE; cyc, stb and we are 0; addr, wdata and sel are 0; rsp_valid, rsp_err and rsp_rdata are 0; req_ready is 0 while reset_in is high.
- Reset asserted mid-cycle drops cyc/stb immediately. No response is issued for the aborted request.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture the request.
  - If aligned with a legal size: drive the bus registers and go to BUS. cyc and stb are high from the next cycle.
  - Otherwise go to RESP with rsp_err = 1 and no bus activity.
- Alignment rules: half requires addr[0] = 0; word requires addr[1:0] = 0; size 3 is always an error.
- bus addr = req_addr, unmodified. The slave does its own base subtraction.
- sel:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << (2 × addr[1])
  - word: 4'b1111
- wdata:
  - byte: replicated in all four lanes
  - half: replicated in both halves
  - word: unchanged
- we = req_we.
- BUS:
  - Hold cyc, stb, addr, we, sel and wdata stable until ack or err is sampled high at a rising edge. Slaves commit stores in the ack cycle.
  - At that edge, drop cyc/stb and go to RESP.
  - If ack and err are both high, err wins.
- Load data:
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Extend using bit 7 or bit 15 unless req_unsigned is set.
  - Register the result on the ack edge.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. req_ready = 0 in BUS and RESP.
- Latency:
  - Accept at edge T; stb high in cycle T+1.
  - Ack sampled at edge T+k (k ≥ 1) gives rsp_valid in cycle T+k+1. A zero-wait slave gives 3 cycles from accept to response.
  - A local error gives rsp_valid in cycle T+1.
- Back-to-back requests: a new request may be accepted in the cycle after RESP. There is no pipelining and at most one transaction is outstanding.

Optional Feature:
- Macro: WB_LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches TimeoutCycles without ack/err, drop cyc/stb at that edge and go to RESP with rsp_err = 1.
  - The counter and parameter logic exist only when the macro is defined.
- Undefined: BUS waits indefinitely. No counter is synthesized.

Decomposition:
- Package lsu_pkg holds:
  - size_t enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD
  - lsu_state_t enum: STATE_IDLE, STATE_BUS, STATE_RESP
- One combinational sub-module, lsu_align:
  - Inputs: size, addr[1:0], wdata, rdata, unsigned flag.
  - Outputs: sel, lane-replicated wdata, extended rdata, misalign flag.
  - This keeps lane logic separately testable.

Test Plan:
- Word store 0xDEADBEEF to 0x3004 with the zero-wait data memory model:
  - Bus shows sel = 4'hF, addr 0x3004, one ack.
  - rsp_valid 3 cycles after accept, rsp_err = 0.
  - Word load from 0x3004 returns 0xDEADBEEF.
- Byte store 0x80 to 0x3001, then signed and unsigned byte loads from 0x3001:
  - Store sel = 4'b0010, wdata = 0x80808080.
  - Loads return 0xFFFFFF80 and 0x00000080.
- Half load from 0x3002 with memory word 0x8001_1234:
  - sel = 4'b1100.
  - Signed load returns 0xFFFF8001; unsigned returns 0x00008001.
- Half load from 0x3003 and word load from 0x3002:
  - No cyc/stb ever asserted.
  - rsp_valid with rsp_err = 1 in cycle T+1.
  - Same result for size = 3 at 0x3000.
- Slave err asserted with ack on the first stb cycle:
  - rsp_err = 1, rsp_rdata = 0.
- Reset and timeout:
  - Assert reset_in mid-BUS: cyc/stb low within the same cycle, no rsp_valid.
  - With WB_LSU_TIMEOUT_EN and TimeoutCycles = 4 against a silent slave: stb high for exactly 4 cycles, then rsp_err = 1.
